// File: rtl/mult_div_pkg.sv
// Shared MIPS constants for the HI/LO multiply-divide unit: opcode/funct
// encodings, default latencies, FSM state type and the arithmetic helpers.
package mult_div_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'b000000;
    localparam logic [5:0] FN_MTHI     = 6'b010001;
    localparam logic [5:0] FN_MTLO     = 6'b010011;
    localparam logic [5:0] FN_MULT     = 6'b011000;
    localparam logic [5:0] FN_MULTU    = 6'b011001;
    localparam logic [5:0] FN_DIV      = 6'b011010;
    localparam logic [5:0] FN_DIVU     = 6'b011011;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    // Full 64-bit product; sign-extending to 64 bits makes the low 64 bits of an
    // unsigned multiply equal to the two's-complement signed product.
    function automatic hilo_t md_mul(input logic [31:0] a, input logic [31:0] b,
                                     input logic is_signed);
        logic [63:0] ax;
        logic [63:0] bx;
        logic [63:0] p;
        ax = is_signed ? {{32{a[31]}}, a} : {32'h0000_0000, a};
        bx = is_signed ? {{32{b[31]}}, b} : {32'h0000_0000, b};
        p  = ax * bx;
        md_mul.hi = p[63:32];
        md_mul.lo = p[31:0];
    endfunction

    // Quotient/remainder via magnitudes; caller guarantees b != 0. Signed
    // 0x80000000 / -1 falls out as 0x80000000 rem 0 with no special case.
    function automatic hilo_t md_div(input logic [31:0] a, input logic [31:0] b,
                                     input logic is_signed);
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        logic        neg_q;
        logic        neg_r;
        neg_q = is_signed & (a[31] ^ b[31]);
        neg_r = is_signed & a[31];
        mag_a = (is_signed && a[31]) ? (32'd0 - a) : a;
        mag_b = (is_signed && b[31]) ? (32'd0 - b) : b;
        q     = mag_a / mag_b;
        r     = mag_a % mag_b;
        md_div.lo = neg_q ? (32'd0 - q) : q;
        md_div.hi = neg_r ? (32'd0 - r) : r;
    endfunction

endpackage

// File: rtl/mult_div_decode.sv
// md_decode: one-hot decode of the HI/LO instructions from an E-stage word.
module md_decode
    import mult_div_pkg::*;
(
    input  logic [31:0] ir,
    output logic        mult,
    output logic        multu,
    output logic        div,
    output logic        divu,
    output logic        mthi,
    output logic        mtlo
);

    logic       special_s;
    logic [5:0] funct_s;
    logic       unused_ir_s;

    assign special_s   = (ir[31:26] == OPC_SPECIAL);
    assign funct_s     = ir[5:0];
    assign unused_ir_s = ^ir[25:6];

    // Funct decode, gated by the SPECIAL opcode.
    always_comb begin
        mult  = 1'b0;
        multu = 1'b0;
        div   = 1'b0;
        divu  = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        if (special_s) begin
            case (funct_s)
                FN_MULT:  mult  = 1'b1;
                FN_MULTU: multu = 1'b1;
                FN_DIV:   div   = 1'b1;
                FN_DIVU:  divu  = 1'b1;
                FN_MTHI:  mthi  = 1'b1;
                FN_MTLO:  mtlo  = 1'b1;
                default:  mult  = 1'b0;
            endcase
        end else begin
            mult = 1'b0;
        end
    end

endmodule

// File: rtl/mult_div.sv
// mult_div: HI/LO multiply-divide unit. The result is computed at issue and
// held in temp registers; a counter models the multi-cycle busy period.
module mult_div
    import mult_div_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_E,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    input  logic        IntReq,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic dec_mult_s, dec_multu_s, dec_div_s, dec_divu_s, dec_mthi_s, dec_mtlo_s;

    md_decode u_decode (
        .ir    (IR_E),
        .mult  (dec_mult_s),
        .multu (dec_multu_s),
        .div   (dec_div_s),
        .divu  (dec_divu_s),
        .mthi  (dec_mthi_s),
        .mtlo  (dec_mtlo_s)
    );

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        hi_tmp_q, hi_tmp_d;
    logic [31:0]        lo_tmp_q, lo_tmp_d;
    logic               wr_q, wr_d;

    logic               is_mul_s;
    logic               is_div_s;
    logic [31:0]        divisor_s;
    hilo_t              mul_res_s;
    hilo_t              div_res_s;

    assign Start     = dec_mult_s | dec_multu_s | dec_div_s | dec_divu_s;
    assign is_mul_s  = dec_mult_s | dec_multu_s;
    assign is_div_s  = dec_div_s | dec_divu_s;
    // Divide-by-zero still runs the busy period but never writes HI/LO, so a
    // harmless divisor keeps the datapath free of undefined results.
    assign divisor_s = (SrcB == 32'd0) ? 32'd1 : SrcB;
    assign mul_res_s = md_mul(SrcA, SrcB, dec_mult_s);
    assign div_res_s = md_div(SrcA, divisor_s, dec_div_s);

    assign Busy = (state_q == ST_BUSY);
    assign HI   = hi_q;
    assign LO   = lo_q;

    // Next-state, counter and HI/LO update logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        wr_d     = wr_q;
        case (state_q)
            ST_IDLE: begin
                if (!IntReq) begin
                    if (is_mul_s) begin
                        hi_tmp_d = mul_res_s.hi;
                        lo_tmp_d = mul_res_s.lo;
                        wr_d     = 1'b1;
                        cnt_d    = CNT_W'(MULT_CYCLES);
                        state_d  = ST_BUSY;
                    end else if (is_div_s) begin
                        hi_tmp_d = div_res_s.hi;
                        lo_tmp_d = div_res_s.lo;
                        wr_d     = (SrcB != 32'd0);
                        cnt_d    = CNT_W'(DIV_CYCLES);
                        state_d  = ST_BUSY;
                    end else if (dec_mthi_s) begin
                        hi_d = SrcA;
                    end else if (dec_mtlo_s) begin
                        lo_d = SrcA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    if (wr_q) begin
                        hi_d = hi_tmp_q;
                        lo_d = lo_tmp_q;
                    end else begin
                        hi_d = hi_q;
                    end
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            hi_tmp_q <= 32'd0;
            lo_tmp_q <= 32'd0;
            wr_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
            wr_q     <= wr_d;
        end
    end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, Busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, Busy cycles for div/divu.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 IR_E  input  32  E-stage instruction; operation decoded internally from opcode [31:26] and funct [5:0].
REQ-006 SrcA  input  32  forwarded rs operand, same value the E-stage ALU receives.
REQ-007 SrcB  input  32  forwarded rt operand.
REQ-008 IntReq  input  1  high when the E-stage instruction is being cancelled by an exception or interrupt this cycle.
REQ-009 Start  output  1  combinational: IR_E is mult/multu/div/divu; drives hazard-unit stalls.
REQ-010 Busy  output  1  registered: a multiply or divide is in flight.
REQ-011 HI  output  32  architectural HI register, read by mfhi through the E-stage result mux.
REQ-012 LO  output  32  architectural LO register, read by mflo.

Function
REQ-013 Decode SHALL use opcode 000000 with funct: mult 011000, multu 011001, div 011010, divu 011011, mthi 010001, mtlo 010011.
REQ-014 SHALL implement a two-state FSM: IDLE and BUSY; Busy=1 exactly in BUSY.
REQ-015 In IDLE with Start=1 and IntReq=0, the edge SHALL latch SrcA, SrcB and the op, compute the result into internal temp registers, load the counter with MULT_CYCLES or DIV_CYCLES, and enter BUSY.
REQ-016 In BUSY the counter SHALL decrement each cycle. At the edge where the counter equals 1, HI/LO SHALL take the temp results and the FSM SHALL return to IDLE. Busy is therefore high for exactly N cycles, and new HI/LO are visible in the first cycle after Busy falls.
REQ-017 mult/multu SHALL produce a 64-bit signed/unsigned product: HI = bits [63:32], LO = bits [31:0].
REQ-018 div/divu SHALL produce LO = quotient and HI = remainder. Signed quotient truncates toward zero, and the remainder takes the sign of the dividend.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000 with no trap.
REQ-020 Divide by zero SHALL run the full DIV_CYCLES Busy period and leave HI/LO unchanged.
REQ-021 mthi/mtlo in IDLE with IntReq=0 SHALL write SrcA to HI/LO at the next edge.
REQ-022 Start, mthi or mtlo arriving while Busy=1 SHALL be ignored; the hazard unit guarantees this does not occur architecturally.
REQ-023 IntReq=1 SHALL suppress a same-cycle Start/mthi/mtlo.
REQ-024 IntReq SHALL NOT cancel an operation already in BUSY; it completes and writes HI/LO.
REQ-025 Start SHALL be purely combinational from IR_E and SHALL be independent of IntReq and Busy.

Reset
REQ-026 Asserting reset SHALL immediately force HI=0, LO=0, Busy=0, counter=0, FSM=IDLE and temp registers=0, including mid-operation; the in-flight result is discarded.
REQ-027 The first edge after reset deassertion SHALL accept a Start normally.

Structure
REQ-028 Funct/opcode constants and the MULT_CYCLES/DIV_CYCLES defaults SHALL live in the shared MIPS constants package used by the decoder and ALU control.
REQ-029 One combinational sub-module md_decode SHALL map IR_E to the one-hot signals mult, multu, div, divu, mthi, mtlo; datapath and FSM stay in mult_div.

Verification
REQ-030 mult with SrcA=0xFFFFFFFF, SrcB=2 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu with the same operands -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-031 div with SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/2 -> LO=3, HI=1.
REQ-032 div with SrcB=0 after mtlo 0x1234 and mthi 0x5678 -> Busy high 10 cycles, then HI=0x5678, LO=0x1234; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 mult with IntReq=1 in the same cycle -> Busy stays 0 and HI/LO unchanged; IntReq pulsed during BUSY -> result still written.
REQ-034 reset asserted in the 3rd Busy cycle of a mult -> Busy=0 and HI=LO=0 without waiting for an edge; next mult after release completes normally.
REQ-035 mthi 0xAAAA issued while Busy -> ignored, so HI equals the mult result; mtlo 0xBBBB in IDLE -> LO=0xBBBB next cycle.
